// File: rtl/mem_responder_pkg.sv
// Shared types and default sizing for the wait-state memory responder.
package mem_responder_pkg;

    localparam int unsigned WORD_SIZE_DEF   = 8;
    localparam int unsigned ADDR_SIZE_DEF   = 8;
    localparam int unsigned WAIT_STATES_DEF = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port storage: synchronous write, synchronous registered read.
module mem_array #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_SIZE;

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [WORD_SIZE-1:0] rdata_q;

    // Storage contents survive reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register holds its value until the next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (en && !we) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory slave that answers each sampled request after WAIT_STATES cycles with a one-cycle ack.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = WORD_SIZE_DEF,
    parameter int unsigned ADDR_SIZE   = ADDR_SIZE_DEF,
    parameter int unsigned WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 req,
    input  logic                 wr,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 ack,
    output logic                 busy
);

    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [CNT_W-1:0] CNT_INIT = NO_WAIT ? '0 : CNT_W'(WAIT_STATES - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 wr_q, wr_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;

    logic                 mem_en_c;
    logic                 mem_we_c;
    logic [ADDR_SIZE-1:0] mem_addr_c;
    logic [WORD_SIZE-1:0] mem_wdata_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // The memory access fires on the edge that moves the FSM into ACK.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        mem_en_c    = 1'b0;
        mem_we_c    = wr_q;
        mem_addr_c  = addr_q;
        mem_wdata_c = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = data_in;
                    wr_d    = wr;
                    if (NO_WAIT) begin
                        // Zero wait states: commit straight from the live inputs.
                        state_d     = ST_ACK;
                        mem_en_c    = 1'b1;
                        mem_we_c    = wr;
                        mem_addr_c  = addr;
                        mem_wdata_c = data_in;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_ACK;
                    mem_en_c = 1'b1;
                end else begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ack_d  = (state_d == ST_ACK);
        busy_d = (state_d != ST_IDLE);
    end

    mem_array #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en_c),
        .we    (mem_we_c),
        .addr  (mem_addr_c),
        .wdata (mem_wdata_c),
        .rdata (data_out)
    );

    assign ack  = ack_q;
    assign busy = busy_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WORD_SIZE, default 8, data width in bits.
REQ-002 Parameter ADDR_SIZE, default 8, address width; storage depth 2**ADDR_SIZE words.
REQ-003 Parameter WAIT_STATES, default 2, range 0..15, cycles between request sample and ack.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 addr  input  ADDR_SIZE  word address from the requester's address register.
REQ-007 data_in  input  WORD_SIZE  write data.
REQ-008 req  input  1  transaction request, level.
REQ-009 wr  input  1  1 = write, 0 = read; qualified by req.
REQ-010 data_out  output  WORD_SIZE  registered read data.
REQ-011 ack  output  1  registered one-cycle completion pulse.
REQ-012 busy  output  1  registered; high while a transaction is in progress.

Function
REQ-013 FSM states IDLE, WAIT, ACK; only IDLE samples req.
REQ-014 IDLE with req=1 at edge E0: latch addr, data_in and wr; go to WAIT with counter = WAIT_STATES-1, or to ACK if WAIT_STATES=0.
REQ-015 WAIT: decrement counter each edge; at the edge where counter = 0, go to ACK.
REQ-016 ack is high for exactly the one cycle following edge E0+WAIT_STATES; ACK always returns to IDLE.
REQ-017 Write commits the latched data_in to the latched address at edge E0+WAIT_STATES.
REQ-018 Read loads data_out from the latched address at edge E0+WAIT_STATES; data_out holds until the next read completes; writes leave data_out unchanged.
REQ-019 busy is high from edge E0 until edge E0+WAIT_STATES+1.
REQ-020 req, addr, data_in and wr changes during WAIT and ACK are ignored.
REQ-021 req held high continuously yields back-to-back transactions with period WAIT_STATES+2 cycles.
REQ-022 A read of a never-written address returns the array's current contents; no X-masking.

Reset
REQ-023 rst=0 asynchronously forces state IDLE, counter 0, data_out 0, ack 0, busy 0.
REQ-024 Reset before the commit edge aborts the transaction; the storage array is unchanged.
REQ-025 The storage array is not reset.

Structure
REQ-026 Package mem_responder_pkg holds the state enum and the default WORD_SIZE, ADDR_SIZE and WAIT_STATES constants.
REQ-027 Storage is one sub-module, mem_array: synchronous write, synchronous read, single port.
REQ-028 The FSM, wait counter and latches reside in mem_responder.

Verification (WAIT_STATES=2 unless stated)
REQ-029 Write 0x3C to 0x10 sampled at E0 -> busy high E0..E3, ack high only after E2; then read 0x10 -> data_out=0x3C with ack.
REQ-030 Assert rst=0 mid-cycle -> data_out=0x00, ack=0, busy=0 immediately, without waiting for a clock edge.
REQ-031 req held high reading 0x10 then 0x11 (pre-written 0xA5) -> ack pulses 4 cycles apart, data_out 0x3C then 0xA5.
REQ-032 Read 0x10 sampled, addr changed to 0x11 during WAIT -> data_out=0x3C.
REQ-033 mem[0x20]=0x11; write 0xFF to 0x20; rst=0 during WAIT -> later read of 0x20 returns 0x11.
REQ-034 WAIT_STATES=0: write then read 0x05 with 0x5A -> ack after each sampling edge, period 2 cycles, data_out=0x5A.
